// File: rtl/m20k_transpose_pkg.sv
// Shared constants for the M20K tile-transpose controller: state codes,
// default read latency and the BRAM address-width helper.
package m20k_transpose_pkg;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam int unsigned DEF_READ_LATENCY = 2;

  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/m20k_out_fifo.sv
// Synchronous output skid FIFO; a push and a pop may share a cycle.
module m20k_out_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the head reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/m20k_transpose_ctrl.sv
// Single-buffer tile transpose: fills the BRAM row-major through port A,
// drains it column-major through port B into a credit-guarded skid FIFO.
module m20k_transpose_ctrl
  import m20k_transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TILE_DIM       = 16,
  parameter int unsigned BRAM_DEPTH     = 2048,
  parameter int unsigned READ_LATENCY   = DEF_READ_LATENCY,
  parameter int unsigned OUT_FIFO_DEPTH = 4,
  localparam int unsigned AW = calc_aw(BRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [AW-1:0]         bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_data_in_a,
  output logic                  bram_wen_a,
  output logic                  bram_ren_a,
  output logic [AW-1:0]         bram_addr_b,
  output logic [DATA_WIDTH-1:0] bram_data_in_b,
  output logic                  bram_wen_b,
  output logic                  bram_ren_b,
  input  logic [DATA_WIDTH-1:0] bram_data_out_b,
  output logic                  busy
);

  localparam int unsigned TILE_ELEMS = TILE_DIM * TILE_DIM;
  localparam int unsigned IW         = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam int unsigned FCW        = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int unsigned IFW        = $clog2(READ_LATENCY + 1);

  logic [0:0]              state_q, state_d;
  logic [AW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]           r_q, r_d;
  logic [IW-1:0]           c_q, c_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    rd_done_q, rd_done_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0] rd_last_q, rd_last_d;

  logic                    rd_issue_c;
  logic                    last_rd_c;
  logic                    drain_done_c;
  logic [IFW-1:0]          inflight;
  logic [FCW-1:0]          fifo_count;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH:0]     fifo_head;

  m20k_out_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_vld_q[READ_LATENCY-1]),
    .push_data_i ({rd_last_q[READ_LATENCY-1], bram_data_out_b}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign inflight  = IFW'($countones(rd_vld_q));
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = fifo_head[DATA_WIDTH];
  assign fifo_pop  = out_valid && out_ready;

  // Credit excludes a same-cycle pop so a slot is never promised twice.
  assign rd_issue_c = (state_q == ST_DRAIN) && !rd_done_q && !fifo_full &&
                      ((32'(fifo_count) + 32'(inflight)) < OUT_FIFO_DEPTH);
  assign last_rd_c  = (r_q == IW'(TILE_DIM - 1)) && (c_q == IW'(TILE_DIM - 1));
  assign drain_done_c = rd_done_q && (inflight == '0) &&
                        (fifo_empty || ((fifo_count == FCW'(1)) && fifo_pop));

  assign in_ready       = (state_q == ST_FILL);
  assign busy           = (state_q == ST_DRAIN);
  assign bram_addr_a    = wr_cnt_q;
  assign bram_data_in_a = in_data;
  assign bram_wen_a     = (state_q == ST_FILL) && in_valid;
  assign bram_ren_a     = 1'b0;
  assign bram_addr_b    = rd_addr_q;
  assign bram_data_in_b = '0;
  assign bram_wen_b     = 1'b0;
  assign bram_ren_b     = rd_issue_c;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    r_d       = r_q;
    c_d       = c_q;
    rd_addr_d = rd_addr_q;
    rd_done_d = rd_done_q;
    rd_vld_d  = (rd_vld_q << 1) | READ_LATENCY'(rd_issue_c);
    rd_last_d = (rd_last_q << 1) | READ_LATENCY'(rd_issue_c && last_rd_c);
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (wr_cnt_q == AW'(TILE_ELEMS - 1)) begin
            state_d  = ST_DRAIN;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Column walk: step by TILE_DIM down a column, restart at c+1 on wrap.
        if (rd_issue_c) begin
          if (r_q == IW'(TILE_DIM - 1)) begin
            r_d       = '0;
            c_d       = c_q + IW'(1);
            rd_addr_d = AW'(c_q) + AW'(1);
            if (c_q == IW'(TILE_DIM - 1)) rd_done_d = 1'b1;
          end else begin
            r_d       = r_q + IW'(1);
            rd_addr_d = rd_addr_q + AW'(TILE_DIM);
          end
        end
        if (drain_done_c) begin
          state_d   = ST_FILL;
          r_d       = '0;
          c_d       = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      wr_cnt_q  <= '0;
      r_q       <= '0;
      c_q       <= '0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      r_q       <= r_d;
      c_q       <= c_d;
      rd_addr_q <= rd_addr_d;
      rd_done_q <= rd_done_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_m20k_transpose_ctrl.sv
// Scoreboard bench: a 4x4 instance for functional/backpressure/reset cases
// and a 16x16 instance for full-throughput timing, each with a BRAM model.
module tb_m20k_transpose_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 11;
  localparam int NA = 4;
  localparam int NB = 16;

  logic   clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Output position j of a transposed NxN tile holds input element (j%N)*N + j/N.
  function automatic int tr_idx(input int j, input int n);
    return (j % n) * n + j / n;
  endfunction

  // ---------------- instance A: 4x4 ----------------
  logic          a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic          a_wen_a, a_ren_a, a_wen_b, a_ren_b, a_busy;
  logic [DW-1:0] a_in_data, a_out_data, a_din_a, a_din_b, a_dout_b;
  logic [AW-1:0] a_addr_a, a_addr_b;

  m20k_transpose_ctrl #(.DATA_WIDTH(DW), .TILE_DIM(NA), .BRAM_DEPTH(2048),
                        .READ_LATENCY(2), .OUT_FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .bram_addr_a(a_addr_a),
    .bram_data_in_a(a_din_a), .bram_wen_a(a_wen_a), .bram_ren_a(a_ren_a),
    .bram_addr_b(a_addr_b), .bram_data_in_b(a_din_b), .bram_wen_b(a_wen_b),
    .bram_ren_b(a_ren_b), .bram_data_out_b(a_dout_b), .busy(a_busy));

  // BRAM model: inputs registered, array access one edge later (latency 2).
  logic [DW-1:0] a_mem [2048];
  logic          a_s_we, a_s_re;
  logic [AW-1:0] a_s_wa, a_s_ra;
  logic [DW-1:0] a_s_wd;
  always @(posedge clk) begin
    a_s_we <= a_wen_a; a_s_wa <= a_addr_a; a_s_wd <= a_din_a;
    a_s_re <= a_ren_b; a_s_ra <= a_addr_b;
    if (a_s_we) a_mem[a_s_wa] <= a_s_wd;
    if (a_s_re) a_dout_b <= a_mem[a_s_ra];
  end

  logic [DW:0]   a_exp_q [$];
  logic [DW-1:0] a_tile [16];
  logic [DW:0]   a_e;
  logic [DW-1:0] a_hold_d;
  int     a_wr_idx = 0, a_rd_idx = 0, a_outs = 0, a_cnt, a_inf, a_rdy_mode = 0;
  bit     a_prev_busy = 0, a_lat_wait = 0, a_last_pend = 0, a_nogap = 1, a_hold = 0;
  longint a_fill_start = 0, a_drain_cyc = 0;

  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (a_rdy_mode)
        0:       a_out_ready = 1'b1;
        1:       a_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: a_out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_wr_idx = 0; a_rd_idx = 0; a_prev_busy = 0; a_lat_wait = 0;
      a_last_pend = 0; a_hold = 0;
    end else begin
      if (a_last_pend) begin
        chk("a_in_ready_after_last", a_in_ready, 1);
        a_last_pend = 0;
      end
      if (a_hold) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_data", a_out_data, a_hold_d);
      end
      chk("a_wen_gate", a_wen_a, a_in_valid && a_in_ready);
      chk("a_in_ready_vs_busy", a_in_ready, !a_busy);
      chk("a_tied_ports", {a_ren_a, a_wen_b, a_din_b}, 0);
      if (a_wen_a) begin
        chk("a_addr_a", a_addr_a, a_wr_idx);
        chk("a_din_a", a_din_a, a_in_data);
        if (a_wr_idx == 0) a_fill_start = cyc;
        a_wr_idx = (a_wr_idx + 1) % 16;
      end
      if (a_busy && !a_prev_busy) begin
        if (a_nogap) chk("a_fill_cycles", cyc - a_fill_start, 16);
        chk("a_ren_at_drain_start", a_ren_b, 1);
        a_drain_cyc = cyc;
        a_lat_wait  = 1;
      end
      if (a_ren_b) begin
        chk("a_addr_b", a_addr_b, tr_idx(a_rd_idx, NA));
        a_rd_idx = (a_rd_idx + 1) % 16;
      end
      if (a_lat_wait && a_out_valid) begin
        chk("a_first_out_latency", cyc - a_drain_cyc, 3);
        a_lat_wait = 0;
      end
      a_cnt = int'(dut_a.u_fifo.count_o);
      a_inf = $countones(dut_a.rd_vld_q);
      chk("a_fifo_count_max", a_cnt <= 4, 1);
      if (a_cnt + a_inf >= 4) chk("a_credit_block", a_ren_b, 0);
      chk("a_no_overflow", dut_a.u_fifo.push_i && dut_a.u_fifo.full_o && !dut_a.u_fifo.pop_i, 0);
      if (a_out_valid && a_out_ready) begin
        if (a_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_out: got %0d expected no output", a_out_data);
        end else begin
          a_e = a_exp_q.pop_front();
          chk("a_out_data", a_out_data, a_e[DW-1:0]);
          chk("a_out_last", a_out_last, a_e[DW]);
        end
        a_outs++;
        if (a_out_last) a_last_pend = 1;
      end
      a_hold   = a_out_valid && !a_out_ready;
      a_hold_d = a_out_data;
      a_prev_busy = a_busy;
    end
  end

  task automatic send_tile_a(input bit gaps);
    bit acc;
    int g;
    for (int j = 0; j < 16; j++) a_exp_q.push_back({1'(j == 15), a_tile[tr_idx(j, NA)]});
    a_nogap = !gaps;
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        while ($urandom_range(1) == 1) begin
          a_in_valid = 1'b0; a_in_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      a_in_valid = 1'b1; a_in_data = a_tile[k];
      acc = 0; g = 0;
      while (!acc) begin
        @(negedge clk); acc = a_in_ready;
        @(posedge clk); #1;
        g++;
        if (g > 400) begin
          checks++; errors++;
          $display("FAIL a_accept_timeout: got in_ready=0 expected 1 within 400 cycles");
          acc = 1;
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_drain_a(input string nm);
    int g = 0;
    while (a_exp_q.size() != 0) begin
      @(posedge clk); g++;
      if (g > 2000) begin
        checks++; errors++;
        $display("FAIL %s: got %0d outputs pending expected 0", nm, a_exp_q.size());
        a_exp_q.delete();
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- instance B: 16x16 ----------------
  logic          b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic          b_wen_a, b_ren_a, b_wen_b, b_ren_b, b_busy;
  logic [DW-1:0] b_in_data, b_out_data, b_din_a, b_din_b, b_dout_b;
  logic [AW-1:0] b_addr_a, b_addr_b;

  m20k_transpose_ctrl dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .bram_addr_a(b_addr_a),
    .bram_data_in_a(b_din_a), .bram_wen_a(b_wen_a), .bram_ren_a(b_ren_a),
    .bram_addr_b(b_addr_b), .bram_data_in_b(b_din_b), .bram_wen_b(b_wen_b),
    .bram_ren_b(b_ren_b), .bram_data_out_b(b_dout_b), .busy(b_busy));

  logic [DW-1:0] b_mem [2048];
  logic          b_s_we, b_s_re;
  logic [AW-1:0] b_s_wa, b_s_ra;
  logic [DW-1:0] b_s_wd;
  always @(posedge clk) begin
    b_s_we <= b_wen_a; b_s_wa <= b_addr_a; b_s_wd <= b_din_a;
    b_s_re <= b_ren_b; b_s_ra <= b_addr_b;
    if (b_s_we) b_mem[b_s_wa] <= b_s_wd;
    if (b_s_re) b_dout_b <= b_mem[b_s_ra];
  end

  logic [DW:0]   b_exp_q [$];
  logic [DW-1:0] b_tile [256];
  logic [DW:0]   b_e;
  int     b_outs = 0;
  bit     b_prev_busy = 0;
  longint b_drain_cyc = 0;

  always @(negedge clk) begin
    if (!b_rst_n) begin
      b_prev_busy = 0; b_outs = 0;
    end else begin
      if (b_ren_a || b_wen_b || (b_din_b != '0)) chk("b_tied_ports", 1, 0);
      if (b_busy && !b_prev_busy) begin
        b_drain_cyc = cyc; b_outs = 0;
      end
      if (b_out_valid && b_out_ready) begin
        if (b_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_out: got %0d expected no output", b_out_data);
        end else begin
          b_e = b_exp_q.pop_front();
          chk("b_out_data", b_out_data, b_e[DW-1:0]);
          chk("b_out_last", b_out_last, b_e[DW]);
        end
        b_outs++;
        if (b_out_last) begin
          chk("b_last_cycle_from_drain", cyc - b_drain_cyc, 258);
          chk("b_out_count", b_outs, 256);
        end
      end
      b_prev_busy = b_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence ----------------
  initial begin
    int o0;
    int g;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ren_b", a_ren_b, 0);
    chk("rst_wen_a", a_wen_a, 0);
    chk("rst_addr_a", a_addr_a, 0);
    chk("rst_addr_b", a_addr_b, 0);
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // contiguous ramp tile, full throughput
    for (int k = 0; k < 16; k++) a_tile[k] = 8'(k);
    o0 = a_outs;
    send_tile_a(1'b0);
    wait_drain_a("t1_drain");
    chk("t1_out_count", a_outs - o0, 16);

    // random input gaps
    send_tile_a(1'b1);
    wait_drain_a("t2_drain");

    // 1,0,0,1 output backpressure on random data
    for (int k = 0; k < 16; k++) a_tile[k] = 8'($urandom);
    a_rdy_mode = 1;
    send_tile_a(1'b0);
    wait_drain_a("t3_drain");
    a_rdy_mode = 0;

    // back-to-back tiles
    for (int k = 0; k < 16; k++) a_tile[k] = 8'(k);
    send_tile_a(1'b0);
    for (int k = 0; k < 16; k++) a_tile[k] = 8'(100 + k);
    send_tile_a(1'b0);
    wait_drain_a("t4_drain");

    // reset mid-drain with reads in flight
    for (int k = 0; k < 16; k++) a_tile[k] = 8'($urandom);
    o0 = a_outs;
    send_tile_a(1'b0);
    g = 0;
    while ((a_outs - o0) < 6 && g < 500) begin @(posedge clk); g++; end
    chk("t5_six_outputs_seen", a_outs - o0 >= 6, 1);
    #1;
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_out_valid", a_out_valid, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_in_ready", a_in_ready, 1);
    chk("t5_rst_ren_b", a_ren_b, 0);
    chk("t5_rst_out_data", a_out_data, 0);
    a_exp_q.delete();
    a_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_stale_out", a_out_valid, 0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) a_tile[k] = 8'($urandom);
    a_rdy_mode = 2;
    send_tile_a(1'b0);
    wait_drain_a("t5_drain");
    a_rdy_mode = 0;

    // 16x16 full-throughput tile
    for (int k = 0; k < 256; k++) b_tile[k] = 8'($urandom);
    for (int j = 0; j < 256; j++) b_exp_q.push_back({1'(j == 255), b_tile[tr_idx(j, NB)]});
    b_in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      b_in_data = b_tile[k];
      @(negedge clk);
      if (!b_in_ready) chk("b_in_ready_fill", b_in_ready, 1);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    g = 0;
    while (b_exp_q.size() != 0 && g < 2000) begin @(posedge clk); g++; end
    chk("b_all_outputs", b_exp_q.size(), 0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
